// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select and IF/ID register.
// Optional perf counters: define FETCH_PERF_CNT_EN.
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JrTarget,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`endif
);

  logic [31:0] pc_plus4;
  logic [31:0] next_sel;
  logic [31:0] next_pc;

  assign pc_plus4 = PC + 32'd4;

  always_comb begin
    next_sel = pc_plus4;
    unique case (PCSrc)
      2'b00: next_sel = pc_plus4;
      2'b01: next_sel = BranchTarget;
      2'b10: next_sel = JumpTarget;
      2'b11: next_sel = JrTarget;
      default: next_sel = pc_plus4;
    endcase
  end

  // Fetch is always word aligned, whatever the redirect source
  assign next_pc = {next_sel[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC               <= 32'h0;
      IFID_Instruction <= 32'h0;
      IFID_PCPlus4     <= 32'h0;
      IFID_Valid       <= 1'b0;
    end else if (!Stall) begin
      PC <= next_pc;
      if (Flush) begin
        IFID_Instruction <= 32'h0;
        IFID_PCPlus4     <= 32'h0;
        IFID_Valid       <= 1'b0;
      end else begin
        IFID_Instruction <= Instruction;
        IFID_PCPlus4     <= pc_plus4;
        IFID_Valid       <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      FetchCount <= 32'h0;
      StallCount <= 32'h0;
    end else begin
      if (Stall)
        StallCount <= StallCount + 32'd1;
      else if (!Flush)
        FetchCount <= FetchCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
// Define FETCH_PERF_CNT_EN to also exercise the perf counters.
module tb_fetch_stage;

  localparam logic [31:0] K = 32'hDEAD0000;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        stall;
  logic        flush;
  logic [1:0]  pcsrc;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pcplus4;
  logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int checks;
  int fails;

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .PC               (pc),
    .Instruction      (instruction),
    .Stall            (stall),
    .Flush            (flush),
    .PCSrc            (pcsrc),
    .BranchTarget     (branch_target),
    .JumpTarget       (jump_target),
    .JrTarget         (jr_target),
    .IFID_Instruction (ifid_instruction),
    .IFID_PCPlus4     (ifid_pcplus4),
    .IFID_Valid       (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount       (fetch_count),
    .StallCount       (stall_count)
`endif
  );

  // Instruction memory stand-in: distinct word per address
  assign instruction = pc ^ K;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] pc_e,
                     input logic [31:0] ins_e, input logic [31:0] p4_e,
                     input logic v_e);
    checks++;
    if (pc !== pc_e || ifid_instruction !== ins_e ||
        ifid_pcplus4 !== p4_e || ifid_valid !== v_e) begin
      fails++;
      $display("FAIL %s: got pc=%h ins=%h p4=%h v=%b want pc=%h ins=%h p4=%h v=%b",
               name, pc, ifid_instruction, ifid_pcplus4, ifid_valid,
               pc_e, ins_e, p4_e, v_e);
    end
  endtask

  task automatic set_in(input logic s, input logic f, input logic [1:0] src);
    stall = s;
    flush = f;
    pcsrc = src;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_in(1'b0, 1'b0, 2'b00);
    branch_target = 32'h0;
    jump_target   = 32'h0;
    jr_target     = 32'h0;
    #2;
    chk("reset_init", 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    step();
    chk("reset_hold_clk", 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_sequential();
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("seq_%0d", i), 32'(4 * i), 32'(4 * (i - 1)) ^ K,
          32'(4 * i), 1'b1);
    end
  endtask

  task automatic test_stall();
    step();
    step();
    step();
    chk("stall_pre", 32'h1C, 32'h18 ^ K, 32'h1C, 1'b1);
    set_in(1'b1, 1'b0, 2'b01);
    branch_target = 32'h200;
    step();
    chk("stall_1", 32'h1C, 32'h18 ^ K, 32'h1C, 1'b1);
    set_in(1'b1, 1'b1, 2'b10);
    jump_target = 32'h100;
    step();
    chk("stall_flush", 32'h1C, 32'h18 ^ K, 32'h1C, 1'b1);
    set_in(1'b0, 1'b0, 2'b00);
    step();
    chk("stall_release", 32'h20, 32'h1C ^ K, 32'h20, 1'b1);
  endtask

  task automatic test_branch_flush();
    step();
    step();
    step();
    chk("br_pre", 32'h2C, 32'h28 ^ K, 32'h2C, 1'b1);
    set_in(1'b0, 1'b1, 2'b01);
    branch_target = 32'h18;
    step();
    chk("br_flush", 32'h18, 32'h0, 32'h0, 1'b0);
    set_in(1'b0, 1'b0, 2'b00);
    step();
    chk("br_after", 32'h1C, 32'h18 ^ K, 32'h1C, 1'b1);
  endtask

  task automatic test_align();
    set_in(1'b0, 1'b0, 2'b11);
    jr_target = 32'h0000_0043;
    step();
    chk("jr_align", 32'h40, 32'h1C ^ K, 32'h20, 1'b1);
    set_in(1'b0, 1'b0, 2'b10);
    jump_target = 32'h0000_1237;
    step();
    chk("jump_align", 32'h1234, 32'h40 ^ K, 32'h44, 1'b1);
    set_in(1'b0, 1'b0, 2'b01);
    branch_target = 32'h0000_0501;
    step();
    chk("branch_align", 32'h500, 32'h1234 ^ K, 32'h1238, 1'b1);
  endtask

  task automatic test_wrap();
    set_in(1'b0, 1'b0, 2'b10);
    jump_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_pre", 32'hFFFF_FFFC, 32'h500 ^ K, 32'h504, 1'b1);
    set_in(1'b0, 1'b0, 2'b00);
    step();
    chk("wrap", 32'h0, 32'hFFFF_FFFC ^ K, 32'h0, 1'b1);
  endtask

  task automatic test_async_reset();
    step();
    step();
    set_in(1'b1, 1'b0, 2'b01);
    branch_target = 32'h80;
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    step();
    chk("async_hold", 32'h0, 32'h0, 32'h0, 1'b0);
    set_in(1'b0, 1'b0, 2'b00);
    reset = 1'b1;
    step();
    chk("async_release", 32'h4, 32'h0 ^ K, 32'h4, 1'b1);
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_cnt();
    #2;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    set_in(1'b0, 1'b0, 2'b00);
    checks++;
    if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
      fails++;
      $display("FAIL perf_reset: got f=%0d s=%0d want 0 0",
               fetch_count, stall_count);
    end
    for (int i = 0; i < 5; i++) step();
    set_in(1'b1, 1'b0, 2'b00);
    step();
    step();
    set_in(1'b0, 1'b1, 2'b00);
    step();
    set_in(1'b0, 1'b0, 2'b00);
    checks++;
    if (fetch_count !== 32'd5 || stall_count !== 32'd2) begin
      fails++;
      $display("FAIL perf_count: got f=%0d s=%0d want 5 2",
               fetch_count, stall_count);
    end
  endtask
`endif

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_flush();
    test_align();
    test_wrap();
    test_async_reset();
`ifdef FETCH_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: PC  out  32  current fetch address, driven to instruction memory Address.
REQ-004 SHALL have port: Instruction  in  32  word returned combinationally by instruction memory for PC.
REQ-005 SHALL have port: Stall  in  1  hazard-unit hold of PC and IF/ID.
REQ-006 SHALL have port: Flush  in  1  replace next IF/ID contents with bubble.
REQ-007 SHALL have port: PCSrc  in  2  next-PC select: 00 PC+4, 01 BranchTarget, 10 JumpTarget, 11 JrTarget.
REQ-008 SHALL have ports: BranchTarget, JumpTarget, JrTarget  in  32 each  redirect addresses from ID.
REQ-009 SHALL have ports: IFID_Instruction  out  32, IFID_PCPlus4  out  32, IFID_Valid  out  1  IF/ID pipeline register.

Function
REQ-010 SHALL compute PCPlus4 = PC + 4 modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-011 SHALL select NextPC per PCSrc, forcing NextPC[1:0] to 2'b00 for every source.
REQ-012 SHALL, when Stall=1, hold PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid unchanged; PCSrc and Flush ignored that cycle.
REQ-013 SHALL, when Stall=0, load PC <= NextPC on the rising edge.
REQ-014 SHALL, when Stall=0 and Flush=0, load IFID_Instruction <= Instruction, IFID_PCPlus4 <= PCPlus4, IFID_Valid <= 1.
REQ-015 SHALL, when Stall=0 and Flush=1, load IFID_Instruction <= 0x00000000 (nop), IFID_PCPlus4 <= 0, IFID_Valid <= 0, while PC still takes NextPC.
REQ-016 SHALL have latency of one cycle: word at PC in cycle n appears on IFID_Instruction after edge ending cycle n.
REQ-017 SHALL contain no combinational path from Stall, Flush or PCSrc to any output.
REQ-018 SHALL treat PC as full 32 bits; address truncation is the memory's concern.

Reset
REQ-019 SHALL, on reset=0, immediately set PC=0x00000000, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, independent of clk.
REQ-020 SHALL, on reset asserted mid-stall or mid-redirect, discard pending selection; first edge after deassertion fetches from 0x00000000 with PCSrc/Stall/Flush honoured normally.
REQ-021 SHALL hold all state at reset values while reset=0 regardless of clk activity.

Configuration
REQ-022 SHALL, with macro FETCH_PERF_CNT_EN defined, add outputs FetchCount out 32 and StallCount out 32.
REQ-023 SHALL, with FETCH_PERF_CNT_EN, increment FetchCount on each edge with Stall=0 and Flush=0, increment StallCount on each edge with Stall=1, both wrap at 2^32, reset to 0.
REQ-024 SHALL, without FETCH_PERF_CNT_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-025 SHALL cover: reset release, PCSrc=00, no stall, 4 edges -> PC 0x4,0x8,0xC,0x10; IFID_PCPlus4 0x4,0x8,0xC; IFID_Valid=1 from first edge.
REQ-026 SHALL cover: PC=0x1C, Stall=1 two edges -> PC stays 0x1C, IF/ID unchanged; Stall=0 next edge -> PC=0x20.
REQ-027 SHALL cover: PC=0x2C, PCSrc=01, BranchTarget=0x18, Flush=1 -> next PC=0x18, IFID_Instruction=0, IFID_Valid=0; following edge IFID_PCPlus4=0x1C.
REQ-028 SHALL cover: PCSrc=11, JrTarget=0x00000043 -> PC=0x00000040; PC=0xFFFFFFFC, PCSrc=00 -> PC=0x00000000.
REQ-029 SHALL cover: Stall=1 and Flush=1 together -> no change; reset=0 asserted between clock edges -> PC=0 and IFID_Valid=0 before next edge.
REQ-030 SHALL cover, with FETCH_PERF_CNT_EN: 5 normal, 2 stalled, 1 flushed edges -> FetchCount=5, StallCount=2.
